// File: rtl/axi_addr_router_pkg.sv
// Shared interconnect definitions: AXI response codes, the response type and
// the burst-length field width used by the address routers.
package axi_addr_router_pkg;

  localparam int AXI_LEN_BITS = 8;

  typedef logic [1:0] resp_t;

  localparam resp_t AXI_RESP_OKAY   = 2'b00;
  localparam resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam resp_t AXI_RESP_SLVERR = 2'b10;
  localparam resp_t AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_default_slave.sv
// Default (unmapped-address) slave. Accepts one burst length per routed
// transaction into a MAX_OUTST-deep FIFO and answers each with DECERR beats.
// Read mode emits len+1 beats with last on the final one; write mode emits a
// single beat per entry.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push, push_len, full address side: enqueue a burst length
//   rsp_valid/last/resp  response beat towards the router's response mux
//   rsp_ready            response accepted
module axi_default_slave
  import axi_addr_router_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter bit IS_WRITE  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [AXI_LEN_BITS-1:0] push_len,
  output logic                    full,
  output logic                    rsp_valid,
  output logic                    rsp_last,
  output resp_t                   rsp_resp,
  input  logic                    rsp_ready
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTST);

  logic [AXI_LEN_BITS-1:0] len_mem [MAX_OUTST];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fill;
  logic [8:0]              beat_cnt;
  logic                    pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The FIFO head is the burst being answered; beat_cnt counts beats already
  // accepted from it, so the first beat is visible the cycle after the push
  // and the next burst follows the last beat with no gap.
  assign full      = (fill == DEPTH);
  assign rsp_valid = (fill != '0);
  assign rsp_last  = IS_WRITE ? 1'b1 : (beat_cnt == {1'b0, len_mem[rd_ptr]});
  assign rsp_resp  = AXI_RESP_DECERR;
  assign pop       = rsp_valid & rsp_ready & rsp_last;

  always_ff @(posedge clk) begin
    if (push) len_mem[wr_ptr] <= push_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
      if (rsp_valid & rsp_ready) beat_cnt <= rsp_last ? '0 : beat_cnt + 9'd1;
    end
  end

endmodule

// File: rtl/axi_addr_router.sv
// AXI address-channel router for one master port (AR or AW). Decodes the
// address against a base table, forwards the handshake to the matching slave
// or to the internal DECERR default slave, and steers the response channel
// back from the slave owning the outstanding transactions.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   I_Addr, I_Len, I_Valid, IB_Ready  master address channel
//   O_Valid, OB_Ready                 per-slave address valid/ready
//   S_RespValid/Last/Resp/Ready       per-slave response channel
//   O_RespValid/Last/Resp, I_RespReady response channel to the master
//   O_RespSel                         current owner, selects external data mux
module axi_addr_router
  import axi_addr_router_pkg::*;
#(
  parameter int                           NUM_SLAVES = 2,
  parameter int                           ADDR_W     = 32,
  parameter int                           MATCH_LSB  = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter int                           MAX_OUTST  = 4,
  parameter bit                           IS_WRITE   = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_W-1:0]                 I_Addr,
  input  logic [AXI_LEN_BITS-1:0]           I_Len,
  input  logic                              I_Valid,
  output logic                              IB_Ready,
  output logic [NUM_SLAVES-1:0]             O_Valid,
  input  logic [NUM_SLAVES-1:0]             OB_Ready,
  input  logic [NUM_SLAVES-1:0]             S_RespValid,
  input  logic [NUM_SLAVES-1:0]             S_RespLast,
  input  logic [2*NUM_SLAVES-1:0]           S_Resp,
  output logic [NUM_SLAVES-1:0]             S_RespReady,
  output logic                              O_RespValid,
  output logic                              O_RespLast,
  output resp_t                             O_Resp,
  input  logic                              I_RespReady,
  output logic [$clog2(NUM_SLAVES+1)-1:0]   O_RespSel
);

  localparam int SEL_W = $clog2(NUM_SLAVES + 1);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int TAG_W = ADDR_W - MATCH_LSB;
  localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [SEL_W-1:0] dest;
  logic [SEL_W-1:0] cur_dest;
  logic [CNT_W-1:0] outst_cnt;
  logic             dest_ready;
  logic             stall;
  logic             go;
  logic             fire;
  logic             retire;
  logic             busy;
  logic             sel_valid;
  logic             sel_last;
  resp_t            sel_resp;
  logic             ds_full;
  logic             ds_valid;
  logic             ds_last;
  resp_t            ds_resp;
  logic             ds_ready;

  if (MATCH_LSB > 0) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^I_Addr[MATCH_LSB-1:0];
  end

  // Address decode: walk downwards so the lowest matching slave wins.
  always_comb begin
    dest = DEF_IDX;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (I_Addr[ADDR_W-1:MATCH_LSB] == SLAVE_BASE[i*ADDR_W+MATCH_LSB +: TAG_W])
        dest = SEL_W'(i);
    end
  end

  always_comb begin
    dest_ready = ~ds_full;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dest == SEL_W'(i)) dest_ready = OB_Ready[i];
    end
  end

  // Only one destination may own outstanding traffic at a time, which keeps
  // responses in order without ID tracking.
  assign stall = (outst_cnt == MAX_CNT) || ((outst_cnt != '0) && (dest != cur_dest));
  assign go    = ~rst & I_Valid & ~stall;

  always_comb begin
    O_Valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) O_Valid[i] = go & (dest == SEL_W'(i));
  end

  assign IB_Ready = go & dest_ready;
  assign fire     = IB_Ready;

  // Response mux from the current owner
  always_comb begin
    sel_valid = ds_valid;
    sel_last  = ds_last;
    sel_resp  = ds_resp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cur_dest == SEL_W'(i)) begin
        sel_valid = S_RespValid[i];
        sel_last  = IS_WRITE ? 1'b1 : S_RespLast[i];
        sel_resp  = S_Resp[2*i +: 2];
      end
    end
  end

  assign busy        = ~rst & (outst_cnt != '0);
  assign O_RespValid = busy & sel_valid;
  assign O_RespLast  = sel_last;
  assign O_Resp      = sel_resp;
  assign O_RespSel   = rst ? '0 : cur_dest;
  assign ds_ready    = busy & I_RespReady & (cur_dest == DEF_IDX);
  assign retire      = O_RespValid & I_RespReady & O_RespLast;

  always_comb begin
    S_RespReady = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      S_RespReady[i] = busy & I_RespReady & (cur_dest == SEL_W'(i));
  end

  // Outstanding tracking; a simultaneous fire and retire leaves the count as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
      cur_dest  <= '0;
    end else begin
      if (fire) cur_dest <= dest;
      case ({fire, retire})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  axi_default_slave #(
    .MAX_OUTST (MAX_OUTST),
    .IS_WRITE  (IS_WRITE)
  ) u_default_slave (
    .clk       (clk),
    .rst       (rst),
    .push      (fire & (dest == DEF_IDX)),
    .push_len  (I_Len),
    .full      (ds_full),
    .rsp_valid (ds_valid),
    .rsp_last  (ds_last),
    .rsp_resp  (ds_resp),
    .rsp_ready (ds_ready)
  );

endmodule

// File: tb/tb_axi_addr_router.sv
module tb_axi_addr_router;
  import axi_addr_router_pkg::*;

  localparam int MAXO = 4;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // read-mode DUT
  logic [31:0] I_Addr;
  logic [7:0]  I_Len;
  logic        I_Valid, IB_Ready;
  logic [1:0]  O_Valid, OB_Ready, S_RespValid, S_RespLast, S_RespReady;
  logic [3:0]  S_Resp;
  logic        O_RespValid, O_RespLast, I_RespReady;
  logic [1:0]  O_Resp, O_RespSel;

  // write-mode DUT
  logic [31:0] w_I_Addr;
  logic [7:0]  w_I_Len;
  logic        w_I_Valid, w_IB_Ready;
  logic [1:0]  w_O_Valid, w_OB_Ready, w_S_RespValid, w_S_RespLast, w_S_RespReady;
  logic [3:0]  w_S_Resp;
  logic        w_O_RespValid, w_O_RespLast, w_I_RespReady;
  logic [1:0]  w_O_Resp, w_O_RespSel;

  int checks = 0;
  int errors = 0;

  axi_addr_router #(.IS_WRITE(1'b0)) dut (
    .clk(clk), .rst(rst), .I_Addr(I_Addr), .I_Len(I_Len), .I_Valid(I_Valid),
    .IB_Ready(IB_Ready), .O_Valid(O_Valid), .OB_Ready(OB_Ready),
    .S_RespValid(S_RespValid), .S_RespLast(S_RespLast), .S_Resp(S_Resp),
    .S_RespReady(S_RespReady), .O_RespValid(O_RespValid), .O_RespLast(O_RespLast),
    .O_Resp(O_Resp), .I_RespReady(I_RespReady), .O_RespSel(O_RespSel)
  );

  axi_addr_router #(.IS_WRITE(1'b1)) wdut (
    .clk(clk), .rst(rst), .I_Addr(w_I_Addr), .I_Len(w_I_Len), .I_Valid(w_I_Valid),
    .IB_Ready(w_IB_Ready), .O_Valid(w_O_Valid), .OB_Ready(w_OB_Ready),
    .S_RespValid(w_S_RespValid), .S_RespLast(w_S_RespLast), .S_Resp(w_S_Resp),
    .S_RespReady(w_S_RespReady), .O_RespValid(w_O_RespValid), .O_RespLast(w_O_RespLast),
    .O_Resp(w_O_Resp), .I_RespReady(w_I_RespReady), .O_RespSel(w_O_RespSel)
  );

  // Reference address map: region tag is address bits [31:16].
  function automatic int ref_dest(input logic [31:0] a);
    if ((a >> 16) == (BASE0 >> 16)) return 0;
    if ((a >> 16) == (BASE1 >> 16)) return 1;
    return 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    I_Addr = '0; I_Len = '0; I_Valid = 0; OB_Ready = '0;
    S_RespValid = '0; S_RespLast = '0; S_Resp = '0; I_RespReady = 0;
    w_I_Addr = '0; w_I_Len = '0; w_I_Valid = 0; w_OB_Ready = '0;
    w_S_RespValid = '0; w_S_RespLast = '0; w_S_Resp = '0; w_I_RespReady = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    I_Valid = 1; I_Addr = 32'h0000_0010; OB_Ready = '1;
    S_RespValid = '1; S_RespLast = '1; I_RespReady = 1;
    w_I_Valid = 1; w_I_Addr = 32'h0000_0010; w_OB_Ready = '1;
    w_S_RespValid = '1; w_I_RespReady = 1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (IB_Ready !== 1'b0) begin errors++; $display("FAIL rst_ib_ready got %0h want 0", IB_Ready); end
      checks++; if (O_Valid !== 2'b00) begin errors++; $display("FAIL rst_o_valid got %0h want 0", O_Valid); end
      checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0h want 0", O_RespValid); end
      checks++; if (S_RespReady !== 2'b00) begin errors++; $display("FAIL rst_s_resp_ready got %0h want 0", S_RespReady); end
      checks++; if (O_RespSel !== 2'd0) begin errors++; $display("FAIL rst_resp_sel got %0h want 0", O_RespSel); end
      checks++; if (w_IB_Ready !== 1'b0) begin errors++; $display("FAIL rst_w_ib_ready got %0h want 0", w_IB_Ready); end
      checks++; if (w_O_RespValid !== 1'b0) begin errors++; $display("FAIL rst_w_resp_valid got %0h want 0", w_O_RespValid); end
    end
    tick();
    rst = 0;
    idle();
  endtask

  task automatic test_slave1_pass();
    I_Addr = 32'h0001_0040; I_Len = 8'd3; I_Valid = 1; OB_Ready = 2'b10;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b10) begin errors++; $display("FAIL s1_o_valid got %0h want 2", O_Valid); end
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL s1_ib_ready got %0h want 1", IB_Ready); end
    tick();
    I_Valid = 0; OB_Ready = '0; I_RespReady = 1;
    for (int b = 0; b < 4; b++) begin
      S_RespValid = 2'b10;
      S_RespLast  = (b == 3) ? 2'b10 : 2'b00;
      S_Resp      = {2'(b), 2'b11};
      @(negedge clk);
      checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL s1_beat%0d_valid got %0h want 1", b, O_RespValid); end
      checks++; if (O_Resp !== 2'(b)) begin errors++; $display("FAIL s1_beat%0d_resp got %0h want %0h", b, O_Resp, 2'(b)); end
      checks++; if (O_RespLast !== (b == 3)) begin errors++; $display("FAIL s1_beat%0d_last got %0h want %0h", b, O_RespLast, (b == 3)); end
      checks++; if (S_RespReady !== 2'b10) begin errors++; $display("FAIL s1_beat%0d_sready got %0h want 2", b, S_RespReady); end
      checks++; if (O_RespSel !== 2'd1) begin errors++; $display("FAIL s1_beat%0d_sel got %0h want 1", b, O_RespSel); end
      tick();
    end
    // slave 1 keeps valid high: nothing outstanding, so it must be blocked
    S_RespLast = '0; I_Valid = 1; I_Addr = 32'h0000_0100; OB_Ready = '0;
    @(negedge clk);
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL s1_after_valid got %0h want 0", O_RespValid); end
    checks++; if (S_RespReady !== 2'b00) begin errors++; $display("FAIL s1_after_sready got %0h want 0", S_RespReady); end
    checks++; if (O_Valid !== 2'b01) begin errors++; $display("FAIL s1_after_unstalled got %0h want 1", O_Valid); end
    tick();
    idle();
  endtask

  task automatic test_default_read();
    int beats;
    I_Addr = 32'h0005_0000; I_Len = 8'd2; I_Valid = 1; OB_Ready = 2'b11; I_RespReady = 0;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b00) begin errors++; $display("FAIL dflt_o_valid got %0h want 0", O_Valid); end
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL dflt_ib_ready got %0h want 1", IB_Ready); end
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL dflt_early_beat got %0h want 0", O_RespValid); end
    tick();
    I_Valid = 0; OB_Ready = '0;
    beats = 0;
    for (int k = 0; k < 20 && beats < 3; k++) begin
      I_RespReady = k[0];
      @(negedge clk);
      checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL dflt_k%0d_valid got %0h want 1", k, O_RespValid); end
      checks++; if (O_Resp !== 2'b11) begin errors++; $display("FAIL dflt_k%0d_resp got %0h want 3", k, O_Resp); end
      checks++; if (O_RespLast !== (beats == 2)) begin errors++; $display("FAIL dflt_k%0d_last got %0h want %0h", k, O_RespLast, (beats == 2)); end
      checks++; if (O_RespSel !== 2'd2) begin errors++; $display("FAIL dflt_k%0d_sel got %0h want 2", k, O_RespSel); end
      checks++; if (S_RespReady !== 2'b00) begin errors++; $display("FAIL dflt_k%0d_sready got %0h want 0", k, S_RespReady); end
      if (I_RespReady) beats++;
      tick();
    end
    I_RespReady = 1;
    @(negedge clk);
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL dflt_extra_beat got %0h want 0", O_RespValid); end
    tick();
    idle();
  endtask

  task automatic test_outst_limit();
    I_Valid = 1; I_Addr = 32'h0000_1234; I_Len = 0; OB_Ready = 2'b01;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL lim_fire%0d got %0h want 1", n, IB_Ready); end
      tick();
    end
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b0) begin errors++; $display("FAIL lim_full_ib_ready got %0h want 0", IB_Ready); end
    checks++; if (O_Valid !== 2'b00) begin errors++; $display("FAIL lim_full_o_valid got %0h want 0", O_Valid); end
    tick();
    S_RespValid = 2'b01; S_RespLast = 2'b01; I_RespReady = 1;
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b0) begin errors++; $display("FAIL lim_retire_cycle_ib got %0h want 0", IB_Ready); end
    checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL lim_retire_valid got %0h want 1", O_RespValid); end
    tick();
    S_RespValid = '0; I_RespReady = 0;
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL lim_after_retire got %0h want 1", IB_Ready); end
    tick();
    I_Valid = 0; S_RespValid = 2'b01; S_RespLast = 2'b01; I_RespReady = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL lim_drain%0d got %0h want 1", n, O_RespValid); end
      tick();
    end
    @(negedge clk);
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL lim_drained got %0h want 0", O_RespValid); end
    tick();
    idle();
  endtask

  task automatic test_dest_switch();
    I_Valid = 1; I_Addr = 32'h0000_0800; OB_Ready = 2'b01;
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL sw_first_fire got %0h want 1", IB_Ready); end
    tick();
    I_Addr = 32'h0001_0800; OB_Ready = 2'b11;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b00) begin errors++; $display("FAIL sw_stall_o_valid got %0h want 0", O_Valid); end
    checks++; if (IB_Ready !== 1'b0) begin errors++; $display("FAIL sw_stall_ib_ready got %0h want 0", IB_Ready); end
    tick();
    S_RespValid = 2'b01; S_RespLast = 2'b01; I_RespReady = 1;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b00) begin errors++; $display("FAIL sw_retire_cycle_o_valid got %0h want 0", O_Valid); end
    checks++; if (O_RespSel !== 2'd0) begin errors++; $display("FAIL sw_retire_sel got %0h want 0", O_RespSel); end
    tick();
    S_RespValid = '0; I_RespReady = 0;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b10) begin errors++; $display("FAIL sw_release_o_valid got %0h want 2", O_Valid); end
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL sw_release_ib_ready got %0h want 1", IB_Ready); end
    tick();
    I_Valid = 0; S_RespValid = 2'b10; S_RespLast = 2'b10; S_Resp = 4'b0100; I_RespReady = 1;
    @(negedge clk);
    checks++; if (O_RespSel !== 2'd1) begin errors++; $display("FAIL sw_new_sel got %0h want 1", O_RespSel); end
    checks++; if (O_Resp !== 2'b01) begin errors++; $display("FAIL sw_new_resp got %0h want 1", O_Resp); end
    checks++; if (S_RespReady !== 2'b10) begin errors++; $display("FAIL sw_new_sready got %0h want 2", S_RespReady); end
    tick();
    idle();
  endtask

  task automatic test_fire_retire();
    I_Valid = 1; I_Addr = 32'h0000_0000; OB_Ready = 2'b01;
    repeat (2) begin
      @(negedge clk);
      checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL fr_fill got %0h want 1", IB_Ready); end
      tick();
    end
    S_RespValid = 2'b01; S_RespLast = 2'b01; I_RespReady = 1;
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL fr_both_ib got %0h want 1", IB_Ready); end
    checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL fr_both_valid got %0h want 1", O_RespValid); end
    tick();
    I_Valid = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++; if (O_RespValid !== 1'b1) begin errors++; $display("FAIL fr_drain%0d got %0h want 1", n, O_RespValid); end
      tick();
    end
    @(negedge clk);
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL fr_count_two got %0h want 0", O_RespValid); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_burst();
    I_Valid = 1; I_Addr = 32'h00F0_0000; I_Len = 8'd5; OB_Ready = '0;
    @(negedge clk);
    checks++; if (IB_Ready !== 1'b1) begin errors++; $display("FAIL rmb_fire got %0h want 1", IB_Ready); end
    tick();
    I_Valid = 0; I_RespReady = 1;
    @(negedge clk);
    checks++; if (O_RespLast !== 1'b0) begin errors++; $display("FAIL rmb_beat0_last got %0h want 0", O_RespLast); end
    tick();
    rst = 1; I_Valid = 1;
    @(negedge clk);
    checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL rmb_rst_valid got %0h want 0", O_RespValid); end
    checks++; if (IB_Ready !== 1'b0) begin errors++; $display("FAIL rmb_rst_ib got %0h want 0", IB_Ready); end
    checks++; if (O_RespSel !== 2'd0) begin errors++; $display("FAIL rmb_rst_sel got %0h want 0", O_RespSel); end
    tick();
    rst = 0; I_Valid = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++; if (O_RespValid !== 1'b0) begin errors++; $display("FAIL rmb_stray%0d got %0h want 0", n, O_RespValid); end
      tick();
    end
    I_Valid = 1; I_Addr = 32'h0001_0000;
    @(negedge clk);
    checks++; if (O_Valid !== 2'b10) begin errors++; $display("FAIL rmb_count_zero got %0h want 2", O_Valid); end
    tick();
    idle();
  endtask

  task automatic test_write_mode();
    w_I_Valid = 1; w_I_Addr = 32'h8000_0000; w_I_Len = 8'd7; w_OB_Ready = 2'b11;
    @(negedge clk);
    checks++; if (w_IB_Ready !== 1'b1) begin errors++; $display("FAIL wr_dflt_ib got %0h want 1", w_IB_Ready); end
    checks++; if (w_O_Valid !== 2'b00) begin errors++; $display("FAIL wr_dflt_o_valid got %0h want 0", w_O_Valid); end
    tick();
    w_I_Valid = 0;
    @(negedge clk);
    checks++; if (w_O_RespValid !== 1'b1) begin errors++; $display("FAIL wr_b_valid got %0h want 1", w_O_RespValid); end
    checks++; if (w_O_Resp !== 2'b11) begin errors++; $display("FAIL wr_b_resp got %0h want 3", w_O_Resp); end
    checks++; if (w_O_RespLast !== 1'b1) begin errors++; $display("FAIL wr_b_last got %0h want 1", w_O_RespLast); end
    checks++; if (w_O_RespSel !== 2'd2) begin errors++; $display("FAIL wr_b_sel got %0h want 2", w_O_RespSel); end
    tick();
    w_I_RespReady = 1;
    @(negedge clk);
    checks++; if (w_O_RespValid !== 1'b1) begin errors++; $display("FAIL wr_b_held got %0h want 1", w_O_RespValid); end
    tick();
    @(negedge clk);
    checks++; if (w_O_RespValid !== 1'b0) begin errors++; $display("FAIL wr_b_single got %0h want 0", w_O_RespValid); end
    tick();
    w_I_RespReady = 0; w_I_Valid = 1; w_I_Addr = 32'h0000_0004; w_OB_Ready = 2'b01;
    @(negedge clk);
    checks++; if (w_IB_Ready !== 1'b1) begin errors++; $display("FAIL wr_s0_fire got %0h want 1", w_IB_Ready); end
    tick();
    w_I_Valid = 0; w_S_RespValid = 2'b01; w_S_RespLast = 2'b00; w_S_Resp = 4'b0010; w_I_RespReady = 1;
    @(negedge clk);
    checks++; if (w_O_RespLast !== 1'b1) begin errors++; $display("FAIL wr_s0_last got %0h want 1", w_O_RespLast); end
    checks++; if (w_O_Resp !== 2'b10) begin errors++; $display("FAIL wr_s0_resp got %0h want 2", w_O_Resp); end
    tick();
    @(negedge clk);
    checks++; if (w_O_RespValid !== 1'b0) begin errors++; $display("FAIL wr_s0_retired got %0h want 0", w_O_RespValid); end
    tick();
    idle();
  endtask

  // Random traffic against a queue-based model: one entry per accepted address,
  // responses come from the oldest entry's destination.
  task automatic test_random();
    int oq[$];
    int lq[$];
    int sp0[$];
    int sp1[$];
    int sbeat0 = 0;
    int sbeat1 = 0;
    int dbeat = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int sel, d, h, exp_sel;
      bit allowed;
      logic exp_ibr, exp_rv, exp_rl;
      logic [1:0] exp_ov, exp_srr, exp_resp;
      sel = $urandom_range(0, 2);
      I_Addr = $urandom;
      if (sel == 0) I_Addr[31:16] = 16'h0000;
      else if (sel == 1) I_Addr[31:16] = 16'h0001;
      else I_Addr[31:16] = 16'($urandom_range(2, 65535));
      I_Len = 8'($urandom_range(0, 3));
      I_Valid = ($urandom_range(0, 3) != 0);
      OB_Ready = 2'($urandom);
      I_RespReady = ($urandom_range(0, 3) != 0);
      S_Resp = 4'($urandom);
      S_RespLast = 2'($urandom);
      S_RespValid = '0;
      if (sp0.size() > 0 && $urandom_range(0, 2) != 0) begin
        S_RespValid[0] = 1'b1; S_RespLast[0] = (sbeat0 == sp0[0]);
      end
      if (sp1.size() > 0 && $urandom_range(0, 2) != 0) begin
        S_RespValid[1] = 1'b1; S_RespLast[1] = (sbeat1 == sp1[0]);
      end

      d = ref_dest(I_Addr);
      allowed = (oq.size() == 0) || (oq.size() < MAXO && oq[0] == d);
      exp_ov  = (I_Valid && allowed && d < 2) ? 2'(1 << d) : 2'b00;
      exp_ibr = I_Valid && allowed && ((d == 2) ? 1'b1 : OB_Ready[d]);
      exp_rv = 0; exp_rl = 0; exp_resp = 2'b00; exp_srr = 2'b00; exp_sel = -1;
      if (oq.size() > 0) begin
        h = oq[0];
        exp_sel = h;
        if (h == 2) begin
          exp_rv = 1; exp_rl = (dbeat == lq[0]); exp_resp = 2'b11;
        end else begin
          exp_rv = S_RespValid[h]; exp_rl = S_RespLast[h]; exp_resp = S_Resp[2*h +: 2];
          exp_srr = I_RespReady ? 2'(1 << h) : 2'b00;
        end
      end

      @(negedge clk);
      checks++; if (IB_Ready !== exp_ibr) begin errors++; $display("FAIL rnd%0d_ib_ready got %0h want %0h", cyc, IB_Ready, exp_ibr); end
      checks++; if (O_Valid !== exp_ov) begin errors++; $display("FAIL rnd%0d_o_valid got %0h want %0h", cyc, O_Valid, exp_ov); end
      checks++; if (O_RespValid !== exp_rv) begin errors++; $display("FAIL rnd%0d_resp_valid got %0h want %0h", cyc, O_RespValid, exp_rv); end
      checks++; if (S_RespReady !== exp_srr) begin errors++; $display("FAIL rnd%0d_s_ready got %0h want %0h", cyc, S_RespReady, exp_srr); end
      if (exp_rv) begin
        checks++; if (O_RespLast !== exp_rl) begin errors++; $display("FAIL rnd%0d_last got %0h want %0h", cyc, O_RespLast, exp_rl); end
        checks++; if (O_Resp !== exp_resp) begin errors++; $display("FAIL rnd%0d_resp got %0h want %0h", cyc, O_Resp, exp_resp); end
      end
      if (exp_sel >= 0) begin
        checks++; if (O_RespSel !== 2'(exp_sel)) begin errors++; $display("FAIL rnd%0d_sel got %0h want %0h", cyc, O_RespSel, exp_sel); end
      end

      if (exp_rv && I_RespReady) begin
        h = oq[0];
        if (h == 0) begin
          if (exp_rl) begin sp0.delete(0); sbeat0 = 0; end else sbeat0++;
        end else if (h == 1) begin
          if (exp_rl) begin sp1.delete(0); sbeat1 = 0; end else sbeat1++;
        end else begin
          dbeat = exp_rl ? 0 : dbeat + 1;
        end
        if (exp_rl) begin oq.delete(0); lq.delete(0); end
      end
      if (exp_ibr) begin
        oq.push_back(d);
        lq.push_back(int'(I_Len));
        if (d == 0) sp0.push_back(int'(I_Len));
        else if (d == 1) sp1.push_back(int'(I_Len));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_slave1_pass();
    test_default_read();
    test_outst_limit();
    test_dest_switch();
    test_fire_retire();
    test_reset_mid_burst();
    test_write_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
